// File: rtl/adder_pkg.sv
// Shared adder definitions: default widths, gather FSM states and the count-width helper.
package adder_pkg;

    localparam int unsigned DEF_BITS = 8;
    localparam int unsigned DEF_NUM  = 8;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } gather_state_t;

    // Width needed to hold the values 0..n inclusive.
    function automatic int unsigned count_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/adder_gather_if.sv
// Stream-in / frame-out handshake bundle of the adder gather front end.
interface adder_gather_if
    import adder_pkg::*;
#(
    parameter int unsigned bits = DEF_BITS,
    parameter int unsigned num  = DEF_NUM
);

    logic                      in_valid;
    logic                      in_ready;
    logic [bits-1:0]           in_data;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic [num*bits-1:0]       out_data;
    logic [count_w(num)-1:0]   out_count;
    logic                      out_partial;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_partial
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_partial
    );

endinterface

// File: rtl/adder_gather_slot.sv
// One gathered word: data register plus valid bit, reading as zero while not valid.
module adder_gather_slot
    import adder_pkg::*;
#(
    parameter int unsigned bits = DEF_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [bits-1:0] d,
    output logic [bits-1:0] q_c
);

    logic [bits-1:0] data;
    logic            valid;

    // Load wins over clear so a word arriving with a frame consume lands in the new frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load) begin
            data  <= d;
            valid <= 1'b1;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end

    assign q_c = valid ? data : '0;

endmodule

// File: rtl/adder_gather.sv
// Gathers num stream words into one zero-padded parallel frame for the adder tree.
module adder_gather
    import adder_pkg::*;
#(
    parameter int unsigned bits = DEF_BITS,
    parameter int unsigned num  = DEF_NUM
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_gather_if.slave  bus
);

    localparam int unsigned CNT_W   = $clog2(num);
    localparam int unsigned COUNT_W = count_w(num);

    gather_state_t                 state;
    gather_state_t                 state_nxt;
    logic [CNT_W-1:0]              cnt;
    logic [COUNT_W-1:0]            count_q;
    logic                          partial_q;
    logic                          valid_c;
    logic                          in_ready_c;
    logic                          accept;
    logic                          consume;
    logic                          last_slot;
    logic                          close;
    logic [num-1:0][bits-1:0]      slot_q;

    assign in_ready_c = !valid_c | bus.out_ready;
    assign accept     = bus.in_valid & in_ready_c;
    assign consume    = valid_c & bus.out_ready;
    assign last_slot  = (cnt == CNT_W'(num - 1));
    assign close      = accept & (last_slot | bus.in_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL:    if (close) state_nxt = HOLD;
            HOLD:    if (consume) state_nxt = close ? HOLD : FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_comb begin
        valid_c = 1'b0;
        case (state)
            HOLD:    valid_c = 1'b1;
            default: valid_c = 1'b0;
        endcase
    end

    // Word counter and frame descriptor captured on the closing word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            count_q   <= '0;
            partial_q <= 1'b0;
        end else if (close) begin
            cnt       <= '0;
            count_q   <= COUNT_W'(cnt) + COUNT_W'(1);
            partial_q <= !last_slot;
        end else begin
            if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (consume) begin
                count_q   <= '0;
                partial_q <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < int'(num); k++) begin : g_slot
        adder_gather_slot #(.bits(bits)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept && (cnt == CNT_W'(k))),
            .clear (consume),
            .d     (bus.in_data),
            .q_c   (slot_q[k])
        );
    end

    assign bus.in_ready    = in_ready_c;
    assign bus.out_valid   = valid_c;
    assign bus.out_data    = slot_q;
    assign bus.out_count   = count_q;
    assign bus.out_partial = partial_q;

endmodule

// File: tb/tb_adder_gather.sv
// Self-checking bench for adder_gather: directed scenarios plus randomized traffic against a queue model.
module tb_adder_gather;

    localparam int unsigned BITS = 8;
    localparam int unsigned NUM  = 8;
    localparam int unsigned CW   = 4;

    logic clk;
    logic rst_n;

    int errors = 0;
    int checks = 0;

    // Reference model: words gathered so far and the pending frame.
    logic [BITS-1:0]      gather[$];
    logic                 m_valid;
    logic [NUM*BITS-1:0]  m_data;
    logic [CW-1:0]        m_count;
    logic                 m_partial;

    adder_gather_if #(.bits(BITS), .num(NUM)) bus ();

    adder_gather #(.bits(BITS), .num(NUM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        gather.delete();
        m_valid   = 1'b0;
        m_data    = '0;
        m_count   = '0;
        m_partial = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [BITS-1:0] d, input logic l, input logic r);
        logic rdy;
        rdy = !m_valid || r;
        if (m_valid && r) m_valid = 1'b0;
        if (v && rdy) begin
            gather.push_back(d);
            if (gather.size() == NUM || l) begin
                m_data = '0;
                foreach (gather[i]) m_data[i*BITS +: BITS] = gather[i];
                m_count   = CW'(gather.size());
                m_partial = (gather.size() < NUM);
                m_valid   = 1'b1;
                gather.delete();
            end
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [BITS-1:0] d, input logic l, input logic r);
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        model_step(v, d, l, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        model_reset();
        #3;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", bus.out_valid); end
        checks++;
        if (bus.out_data !== 64'h0) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.out_data); end
        checks++;
        if (bus.out_count !== 4'd0 || bus.out_partial !== 1'b0) begin
            errors++; $display("FAIL reset_count: got count=%0d partial=%0b expected 0/0", bus.out_count, bus.out_partial);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 1; i <= 8; i++) begin
                drive(1'b1, BITS'(i), (pass == 1 && i == 8), 1'b1);
                checks++;
                if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready: got %0b expected 1 at word %0d", bus.in_ready, i); end
                if (i < 8) begin
                    checks++;
                    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid: got %0b expected 0 at word %0d", bus.out_valid, i); end
                end
            end
            checks++;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL full_valid: got %0b expected 1", bus.out_valid); end
            checks++;
            if (bus.out_data !== 64'h0807060504030201) begin errors++; $display("FAIL full_data: got %h expected 0807060504030201", bus.out_data); end
            checks++;
            if (bus.out_count !== 4'd8 || bus.out_partial !== 1'b0) begin
                errors++; $display("FAIL full_count: got count=%0d partial=%0b expected 8/0", bus.out_count, bus.out_partial);
            end
            drive(1'b0, '0, 1'b0, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_consume: got %0b expected 0", bus.out_valid); end
        end
    endtask

    task automatic test_early_term();
        drive(1'b1, 8'd5, 1'b0, 1'b1);
        drive(1'b1, 8'd6, 1'b0, 1'b1);
        drive(1'b1, 8'd7, 1'b1, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0000000000070605) begin
            errors++; $display("FAIL early_data: got valid=%0b data=%h expected 1/0000000000070605", bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.out_count !== 4'd3 || bus.out_partial !== 1'b1) begin
            errors++; $display("FAIL early_count: got count=%0d partial=%0b expected 3/1", bus.out_count, bus.out_partial);
        end
        drive(1'b1, 8'd9, 1'b1, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0000000000000009) begin
            errors++; $display("FAIL early_no_stale: got valid=%0b data=%h expected 1/0000000000000009", bus.out_valid, bus.out_data);
        end
        checks++;
        if (bus.out_count !== 4'd1 || bus.out_partial !== 1'b1) begin
            errors++; $display("FAIL early_single: got count=%0d partial=%0b expected 1/1", bus.out_count, bus.out_partial);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [63:0] frame;
        frame = 64'h2827262524232221;
        for (int i = 1; i <= 8; i++) drive(1'b1, BITS'(8'h20 + i), 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== frame) begin
            errors++; $display("FAIL bp_frame: got valid=%0b data=%h expected 1/%h", bus.out_valid, bus.out_data, frame);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h11, 1'b0, 1'b0);
            checks++;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %0b expected 0 in stall %0d", bus.in_ready, i); end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== frame || bus.out_count !== 4'd8) begin
                errors++; $display("FAIL bp_stable: got valid=%0b data=%h count=%0d expected 1/%h/8", bus.out_valid, bus.out_data, bus.out_count, frame);
            end
        end
        drive(1'b1, 8'h11, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0000000000000011) begin
            errors++; $display("FAIL bp_slot0: got valid=%0b data=%h expected 0/0000000000000011", bus.out_valid, bus.out_data);
        end
        drive(1'b1, 8'h12, 1'b1, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 64'h0000000000001211 || bus.out_count !== 4'd2 || bus.out_partial !== 1'b1) begin
            errors++; $display("FAIL bp_next_frame: got valid=%0b data=%h count=%0d partial=%0b expected 1/1211/2/1",
                               bus.out_valid, bus.out_data, bus.out_count, bus.out_partial);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [BITS-1:0] d;
        for (int i = 0; i < 6; i++) begin
            d = BITS'($urandom);
            drive(1'b1, d, 1'b1, 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== {56'h0, d} || bus.out_count !== 4'd1 || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_frame: got valid=%0b data=%h count=%0d ready=%0b expected 1/%h/1/1",
                                   bus.out_valid, bus.out_data, bus.out_count, bus.in_ready, d);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        drive(1'b1, 8'h01, 1'b0, 1'b1);
        drive(1'b1, 8'h02, 1'b0, 1'b1);
        drive(1'b1, 8'h03, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 64'h0 || bus.out_count !== 4'd0 || bus.out_partial !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got valid=%0b data=%h count=%0d partial=%0b expected all 0",
                               bus.out_valid, bus.out_data, bus.out_count, bus.out_partial);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %0b expected 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) drive(1'b1, 8'hFF, 1'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== {8{8'hFF}} || bus.out_count !== 4'd8 || bus.out_partial !== 1'b0) begin
            errors++; $display("FAIL midrst_frame: got valid=%0b data=%h count=%0d partial=%0b expected 1/all FF/8/0",
                               bus.out_valid, bus.out_data, bus.out_count, bus.out_partial);
        end
        drive(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        logic v;
        logic l;
        logic r;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 4) == 0);
            r = ($urandom_range(0, 9) < 7);
            drive(v, BITS'($urandom), l, r);
            checks++;
            if (bus.out_valid !== m_valid || bus.in_ready !== (!m_valid || r)) begin
                errors++; $display("FAIL rand_handshake: cycle %0d got valid=%0b ready=%0b expected %0b/%0b",
                                   i, bus.out_valid, bus.in_ready, m_valid, (!m_valid || r));
            end
            if (m_valid) begin
                checks++;
                if (bus.out_data !== m_data || bus.out_count !== m_count || bus.out_partial !== m_partial) begin
                    errors++; $display("FAIL rand_frame: cycle %0d got data=%h count=%0d partial=%0b expected %h/%0d/%0b",
                                       i, bus.out_data, bus.out_count, bus.out_partial, m_data, m_count, m_partial);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_early_term();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
